// File: rtl/core_pkg.sv
// Shared constants for the fetch PC generator and its branch target buffer.
package core_pkg;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t    CTR_WEAK_T = 2'b10;
  localparam btb_ctr_t    CTR_MAX    = 2'b11;
  localparam btb_ctr_t    CTR_MIN    = 2'b00;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB: combinational lookup port, posedge training port, async valid clear.
module btb_table
  import core_pkg::*;
#(
  parameter int unsigned WordSize   = 32,
  parameter int unsigned BtbEntries = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [WordSize-3:0] lookup_wa,
  output logic                pred_taken,
  output logic [WordSize-3:0] pred_target,
  input  logic                upd_valid,
  input  logic [WordSize-3:0] upd_wa,
  input  logic [WordSize-3:0] upd_target,
  input  logic                upd_taken
);

  localparam int unsigned IW = $clog2(BtbEntries);
  localparam int unsigned TW = WordSize - 2 - IW;

  // Width depends on the module parameters, so the entry type lives here.
  typedef struct packed {
    logic [TW-1:0]       tag;
    logic [WordSize-3:0] target;
    btb_ctr_t            ctr;
  } btb_entry_t;

  btb_entry_t entries [BtbEntries];
  logic       valid_q [BtbEntries];

  logic [IW-1:0] rd_idx, wr_idx;
  logic [TW-1:0] rd_tag, wr_tag;
  logic          rd_hit, wr_hit;

  assign rd_idx = lookup_wa[IW-1:0];
  assign rd_tag = lookup_wa[WordSize-3:IW];
  assign wr_idx = upd_wa[IW-1:0];
  assign wr_tag = upd_wa[WordSize-3:IW];

  assign rd_hit      = valid_q[rd_idx] && (entries[rd_idx].tag == rd_tag);
  assign wr_hit      = valid_q[wr_idx] && (entries[wr_idx].tag == wr_tag);
  assign pred_taken  = rd_hit && entries[rd_idx].ctr[1];
  assign pred_target = entries[rd_idx].target;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < BtbEntries; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid && !wr_hit && upd_taken) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (wr_hit) begin
        if (upd_taken) begin
          entries[wr_idx].target <= upd_target;
          if (entries[wr_idx].ctr != CTR_MAX) entries[wr_idx].ctr <= entries[wr_idx].ctr + 2'd1;
        end else if (entries[wr_idx].ctr != CTR_MIN) begin
          entries[wr_idx].ctr <= entries[wr_idx].ctr - 2'd1;
        end
      end else if (upd_taken) begin
        entries[wr_idx] <= '{tag: wr_tag, target: upd_target, ctr: CTR_WEAK_T};
      end
    end
  end

endmodule

// File: rtl/if_pc_btb.sv
// Fetch PC register with BTB-driven next-PC selection and mispredict redirect.
module if_pc_btb
  import core_pkg::*;
#(
  parameter int unsigned          WordSize    = 32,
  parameter int unsigned          BtbEntries  = 16,
  parameter logic [WordSize-1:0]  ResetVector = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                flush,
  input  logic [WordSize-1:0] redirect_pc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic [WordSize-1:0] upd_target,
  input  logic                upd_taken,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] pred_pc,
  output logic                pred_taken,
  output logic                fetch_valid
);

  logic [WordSize-1:0] pc_q;
  logic                fetch_valid_q;
  logic [WordSize-3:0] btb_target;
  logic                unused_low_bits;

  assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

  btb_table #(
    .WordSize   (WordSize),
    .BtbEntries (BtbEntries)
  ) u_btb (
    .clk         (clk),
    .rstn        (rstn),
    .lookup_wa   (pc_q[WordSize-1:2]),
    .pred_taken  (pred_taken),
    .pred_target (btb_target),
    .upd_valid   (upd_valid),
    .upd_wa      (upd_pc[WordSize-1:2]),
    .upd_target  (upd_target[WordSize-1:2]),
    .upd_taken   (upd_taken)
  );

  assign pc          = pc_q;
  assign pred_pc     = pred_taken ? {btb_target, 2'b00} : pc_q + WordSize'(PC_STEP);
  assign fetch_valid = fetch_valid_q && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q          <= ResetVector;
      fetch_valid_q <= 1'b0;
    end else if (flush) begin
      pc_q          <= {redirect_pc[WordSize-1:2], 2'b00};
      fetch_valid_q <= 1'b1;
    end else if (!stall) begin
      pc_q          <= pred_pc;
      fetch_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_pc_btb.sv
// Directed bench for if_pc_btb: sequencing, training, aliasing, redirect, wrap and reset.
module tb_if_pc_btb;

  logic        clk = 1'b0;
  logic        rstn, stall, flush, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] pc, pred_pc;
  logic        pred_taken, fetch_valid;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  if_pc_btb #(
    .WordSize    (32),
    .BtbEntries  (16),
    .ResetVector (32'h0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .pc          (pc),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .fetch_valid (fetch_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid = 1'b1; upd_pc = p; upd_target = t; upd_taken = tk;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] r);
    flush = 1'b1; redirect_pc = r;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
    checks++; if (pred_pc !== 32'h4) begin errors++; $display("FAIL reset_pred_pc: got %h want %h", pred_pc, 32'h4); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
    step();
    checks++; if (pc !== 32'h4 || fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_1: pc %h fv %b want 00000004 1", pc, fetch_valid); end
    step();
    checks++; if (pc !== 32'h8 || pred_taken !== 1'b0) begin errors++; $display("FAIL seq_2: pc %h pt %b want 00000008 0", pc, pred_taken); end
  endtask

  task automatic test_taken();
    int n;
    train(32'h40, 32'h100, 1'b1);
    n = 0;
    while (pc !== 32'h40 && n < 100) begin step(); n++; end
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL reach_40: got %h want %h", pc, 32'h40); end
    checks++; if (pred_taken !== 1'b1 || pred_pc !== 32'h100) begin errors++; $display("FAIL hit_40: pt %b pred %h want 1 00000100", pred_taken, pred_pc); end
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL follow_target: got %h want %h", pc, 32'h100); end
  endtask

  task automatic test_counter();
    upd_valid = 1'b1; upd_pc = 32'h40; upd_target = 32'h0; upd_taken = 1'b0;
    redirect(32'h40);
    upd_valid = 1'b0;
    checks++; if (pred_taken !== 1'b0 || pred_pc !== 32'h44) begin errors++; $display("FAIL ctr01: pt %b pred %h want 0 00000044", pred_taken, pred_pc); end
    step();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL ctr01_next: got %h want %h", pc, 32'h44); end
    stall = 1'b1;
    redirect(32'h40);
    repeat (3) train(32'h40, 32'h100, 1'b1);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_hold: got %h want %h", pc, 32'h40); end
    checks++; if (pred_taken !== 1'b1 || pred_pc !== 32'h100) begin errors++; $display("FAIL ctr11: pt %b pred %h want 1 00000100", pred_taken, pred_pc); end
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL read_before_write: got %b want 1", pred_taken); end
    step();
    upd_valid = 1'b0;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL saturate_ctr10: got %b want 1", pred_taken); end
    train(32'h40, 32'h0, 1'b0);
    checks++; if (pred_taken !== 1'b0 || pred_pc !== 32'h44) begin errors++; $display("FAIL ctr01_again: pt %b pred %h want 0 00000044", pred_taken, pred_pc); end
  endtask

  task automatic test_alias();
    train(32'h40, 32'h100, 1'b1);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL retrain_40: got %b want 1", pred_taken); end
    train(32'h440, 32'h200, 1'b1);
    checks++; if (pred_taken !== 1'b0 || pred_pc !== 32'h44) begin errors++; $display("FAIL alias_miss: pt %b pred %h want 0 00000044", pred_taken, pred_pc); end
    train(32'h40, 32'h300, 1'b0);
    redirect(32'h440);
    checks++; if (pc !== 32'h440 || pred_taken !== 1'b1 || pred_pc !== 32'h200) begin errors++; $display("FAIL alias_hit: pc %h pt %b pred %h want 00000440 1 00000200", pc, pred_taken, pred_pc); end
  endtask

  task automatic test_flush();
    flush = 1'b1; redirect_pc = 32'h203;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL flush_squash: got %b want 0", fetch_valid); end
    step();
    flush = 1'b0;
    #1;
    checks++; if (pc !== 32'h200 || fetch_valid !== 1'b1) begin errors++; $display("FAIL flush_pc: pc %h fv %b want 00000200 1", pc, fetch_valid); end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    checks++; if (pc !== 32'hFFFF_FFFC || pred_taken !== 1'b0 || pred_pc !== 32'h0) begin errors++; $display("FAIL wrap_pred: pc %h pt %b pred %h want fffffffc 0 00000000", pc, pred_taken, pred_pc); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
  endtask

  task automatic test_reset_mid();
    redirect(32'h440);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %b want 1", pred_taken); end
    #2;
    flush = 1'b1; redirect_pc = 32'h80; rstn = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL async_reset: pc %h fv %b want 00000000 0", pc, fetch_valid); end
    repeat (2) step();
    rstn = 1'b1; flush = 1'b0;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL redirect_dropped: got %h want %h", pc, 32'h4); end
    redirect(32'h440);
    checks++; if (pred_taken !== 1'b0 || pred_pc !== 32'h444) begin errors++; $display("FAIL btb_cleared: pt %b pred %h want 0 00000444", pred_taken, pred_pc); end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_counter();
    test_alias();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
